// File: rtl/program_loader.sv
// program_loader: receives a SYNC/count/payload/checksum byte stream, writes 32-bit words
// into instruction memory and holds the processor in reset until a packet verifies.
module program_loader #(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);
  localparam int MAX_WORDS = 2**ADDR_W;
  localparam int TW        = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CHECK, RUN, ERROR} state_t;

  state_t            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [7:0]        chk_q, chk_d;
  logic [31:0]       word_q, word_d, word_n;
  logic [1:0]        bidx_q, bidx_d;
  logic [ADDR_W:0]   widx_q, widx_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              acc, timed, is_sync;
  logic [15:0]       cnt_full;

  assign rx_ready   = ~we_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;

  always_comb begin
    acc         = rx_valid & rx_ready;
    is_sync     = rx_data == SYNC_BYTE;
    timed       = state_q inside {CNT_LO, CNT_HI, DATA, CHECK};
    cnt_full    = {rx_data, count_q[7:0]};
    word_n      = word_q;
    word_n[8*bidx_q +: 8] = rx_data;
    state_d     = state_q;
    count_d     = count_q;
    chk_d       = chk_q;
    word_d      = word_q;
    bidx_d      = bidx_q;
    widx_d      = widx_q;
    timer_d     = (!timed || acc) ? '0 : timer_q + 1'b1;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;
    case (state_q)
      IDLE, RUN, ERROR: if (acc && is_sync) begin
        state_d     = CNT_LO;
        chk_d       = '0;
        widx_d      = '0;
        bidx_d      = '0;
        cpu_reset_d = 1'b1;
        done_d      = 1'b0;
        error_d     = 1'b0;
      end
      CNT_LO: if (acc) begin
        count_d[7:0] = rx_data;
        chk_d        = rx_data;
        state_d      = CNT_HI;
      end
      CNT_HI: if (acc) begin
        count_d = cnt_full;
        chk_d   = chk_q ^ rx_data;
        state_d = (cnt_full == '0) ? CHECK : (int'(cnt_full) > MAX_WORDS) ? ERROR : DATA;
        error_d = int'(cnt_full) > MAX_WORDS;
      end
      DATA: if (acc) begin
        chk_d  = chk_q ^ rx_data;
        word_d = word_n;
        bidx_d = bidx_q + 2'd1;
        if (bidx_q == 2'd3) begin
          we_d    = 1'b1;
          wdata_d = word_n;
          addr_d  = widx_q[ADDR_W-1:0];
          widx_d  = widx_q + 1'b1;
          state_d = (int'(widx_q) + 1 == int'(count_q)) ? CHECK : DATA;
        end
      end
      CHECK: if (acc) begin
        state_d     = (rx_data == chk_q) ? RUN : ERROR;
        cpu_reset_d = rx_data != chk_q;
        done_d      = rx_data == chk_q;
        error_d     = rx_data != chk_q;
      end
      default: state_d = IDLE;
    endcase
    if (timed && !acc && timer_q == TW'(TIMEOUT - 1)) begin
      state_d = ERROR;
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      chk_q       <= '0;
      word_q      <= '0;
      bidx_q      <= '0;
      widx_q      <= '0;
      timer_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      chk_q       <= chk_d;
      word_q      <= word_d;
      bidx_q      <= bidx_d;
      widx_q      <= widx_d;
      timer_q     <= timer_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed packet scenarios against program_loader with a write-capture model.
module tb_program_loader;
  localparam int T = 16;
  logic        clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready, imem_we, cpu_reset, done, error;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [31:0] mem [0:255];
  int          wcount = 0, we_cyc = 0, rdy_low = 0, rr_bad = 0, we_long = 0;
  int          errors = 0, checks = 0;
  logic        we_prev = 1'b0;
  logic [7:0]  last_addr = '0;

  program_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      mem[imem_addr] = imem_wdata;
      last_addr = imem_addr;
      wcount++;
      we_cyc++;
    end
    if (imem_we && we_prev) we_long++;
    we_prev = imem_we;
    if (rx_valid && !rx_ready) rdy_low++;
    if (rx_ready !== ~imem_we) rr_bad++;
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_stall: rx_ready stuck at %b, required 1", rx_ready);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_good();
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    send(8'h28);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cpu_reset, rx_ready, imem_we, imem_addr, imem_wdata, done, error} !== {1'b1, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got cr=%b rdy=%b we=%b a=%h d=%h done=%b err=%b, required 1 1 0 00 00000000 0 0",
               cpu_reset, rx_ready, imem_we, imem_addr, imem_wdata, done, error);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_garbage();
    send(8'h11); send(8'h22); idle(3);
    checks++;
    if ({error, done, cpu_reset} !== 3'b001) begin
      errors++; $display("FAIL garbage_idle: err/done/cr=%b, required 001", {error, done, cpu_reset});
    end
    checks++;
    if (wcount !== 0) begin
      errors++; $display("FAIL garbage_writes: got %0d, required 0", wcount);
    end
  endtask

  task automatic test_basic();
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    checks++;
    if (done !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++; $display("FAIL basic_pre_chk: done=%b cr=%b, required 0 1", done, cpu_reset);
    end
    send(8'h28);
    rx_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL basic_release: done=%b cr=%b err=%b, required 1 0 0", done, cpu_reset, error);
    end
    idle(2);
    checks++;
    if (wcount !== 2 || mem[0] !== 32'h12345678 || mem[1] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_writes: n=%0d m0=%h m1=%h, required 2 12345678 deadbeef", wcount, mem[0], mem[1]);
    end
  endtask

  task automatic test_bad_chk();
    int w0 = wcount;
    mem[0] = '0; mem[1] = '0;
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    send(8'hD7);
    idle(2);
    checks++;
    if ({error, cpu_reset, done} !== 3'b110) begin
      errors++; $display("FAIL badchk_flags: err/cr/done=%b, required 110", {error, cpu_reset, done});
    end
    checks++;
    if (wcount - w0 !== 2 || mem[1] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL badchk_writes: n=%0d m1=%h, required 2 deadbeef", wcount - w0, mem[1]);
    end
    send_good();
    idle(1);
    checks++;
    if ({done, error, cpu_reset} !== 3'b100) begin
      errors++; $display("FAIL badchk_resend: done/err/cr=%b, required 100", {done, error, cpu_reset});
    end
  endtask

  task automatic test_restart();
    send(8'hA5);
    rx_valid = 1'b0;
    checks++;
    if (cpu_reset !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL restart_hold: cr=%b done=%b, required 1 0", cpu_reset, done);
    end
    send(8'h01); send(8'h00); send(8'h44); send(8'h33); send(8'h22); send(8'h11);
    send(8'h45);
    idle(1);
    checks++;
    if (mem[0] !== 32'h11223344 || last_addr !== 8'h00 || done !== 1'b1 || cpu_reset !== 1'b0) begin
      errors++; $display("FAIL restart_word: m0=%h a=%h done=%b cr=%b, required 11223344 00 1 0", mem[0], last_addr, done, cpu_reset);
    end
  endtask

  task automatic test_count_bounds();
    int w0 = wcount;
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    idle(3);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || wcount !== w0) begin
      errors++; $display("FAIL count0: done=%b err=%b writes=%0d, required 1 0 0", done, error, wcount - w0);
    end
    send(8'hA5); send(8'h01); send(8'h01);
    rx_valid = 1'b0;
    checks++;
    if ({error, cpu_reset, done} !== 3'b110) begin
      errors++; $display("FAIL count_over: err/cr/done=%b, required 110", {error, cpu_reset, done});
    end
  endtask

  task automatic test_max_words();
    int w0 = wcount;
    send(8'hA5); send(8'h00); send(8'h01);
    for (int i = 0; i < 256; i++) begin
      send(8'(i)); send(8'h00); send(8'h00); send(8'h00);
    end
    send(8'h01);
    idle(2);
    checks++;
    if (wcount - w0 !== 256 || mem[0] !== 32'h0 || mem[255] !== 32'hFF || last_addr !== 8'hFF) begin
      errors++; $display("FAIL max_words: n=%0d m0=%h m255=%h a=%h, required 256 00000000 000000ff ff", wcount - w0, mem[0], mem[255], last_addr);
    end
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL max_release: done=%b err=%b, required 1 0", done, error);
    end
  endtask

  task automatic test_timeout();
    int w0 = wcount;
    send(8'hA5); send(8'h01); send(8'h00); send(8'h44); send(8'h33);
    idle(T - 1);
    checks++;
    if (error !== 1'b0) begin
      errors++; $display("FAIL timeout_early: err=%b, required 0", error);
    end
    idle(1);
    checks++;
    if ({error, cpu_reset, done} !== 3'b110 || wcount !== w0) begin
      errors++; $display("FAIL timeout_fire: err/cr/done=%b writes=%0d, required 110 0", {error, cpu_reset, done}, wcount - w0);
    end
  endtask

  task automatic test_back_to_back();
    mem[0] = '0; mem[1] = '0;
    we_cyc = 0; rdy_low = 0;
    send_good();
    idle(2);
    checks++;
    if (we_cyc !== 2 || rdy_low !== 2) begin
      errors++; $display("FAIL b2b_backpressure: we=%0d rdy_low=%0d, required 2 2", we_cyc, rdy_low);
    end
    checks++;
    if (mem[0] !== 32'h12345678 || mem[1] !== 32'hDEADBEEF || done !== 1'b1) begin
      errors++; $display("FAIL b2b_data: m0=%h m1=%h done=%b, required 12345678 deadbeef 1", mem[0], mem[1], done);
    end
    checks++;
    if (rr_bad !== 0 || we_long !== 0) begin
      errors++; $display("FAIL ready_we_rule: rr_bad=%0d we_long=%0d, required 0 0", rr_bad, we_long);
    end
  endtask

  task automatic test_mid_reset();
    int w0;
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12); send(8'hEF);
    rx_valid = 1'b0;
    w0 = wcount;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_reset, rx_ready, imem_we, imem_addr, imem_wdata, done, error} !== {1'b1, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_async: cr=%b rdy=%b we=%b a=%h d=%h done=%b err=%b, required 1 1 0 00 00000000 0 0",
               cpu_reset, rx_ready, imem_we, imem_addr, imem_wdata, done, error);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    checks++;
    if (wcount !== w0 || cpu_reset !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL midreset_after: writes=%0d cr=%b done=%b, required 0 1 0", wcount - w0, cpu_reset, done);
    end
  endtask

  initial begin
    test_reset();
    test_garbage();
    test_basic();
    test_bad_chk();
    test_restart();
    test_count_bounds();
    test_max_words();
    test_timeout();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
